// File: rtl/trilat_pkg.sv
// trilat_pkg: shared FSM state encoding, default geometry and datapath widths
// for the trilateration locator.
package trilat_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        ERR   = 3'd2,
        DIV_X = 3'd3,
        DIV_Y = 3'd4,
        DIV_C = 3'd5,
        DIV_R = 3'd6,
        DONE  = 3'd7
    } state_e;

    localparam int DEF_W        = 12;
    localparam int DEF_SIDE     = 75;
    localparam int DEF_XS3      = 37;
    localparam int DEF_YS3      = 66;
    localparam int DEF_MAX_DIST = 127;
    localparam int DEF_ROWS     = 8;
    localparam int DEF_COLS     = 8;

    // Numerator width and divider width coincide: one quotient bit per numerator bit.
    function automatic int calc_dw(input int w);
        return 2 * w + 3;
    endfunction

    localparam int NW = calc_dw(DEF_W);
    localparam int DW = NW;

endpackage

// File: rtl/trilat_locator_div.sv
// serial_div: unsigned restoring divider, one quotient bit per cycle; the start
// cycle already produces the first bit, so a division takes exactly DW cycles.
module serial_div #(
    parameter int DW = 27
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic [DW-1:0] quotient,
    output logic          done
);

    localparam int CNTW = $clog2(DW + 1);

    logic [DW-1:0]   rem_r;
    logic [DW-1:0]   quo_r;
    logic [DW-1:0]   dvs_r;
    logic [CNTW-1:0] cnt_r;
    logic            busy_r;
    logic            done_r;

    logic [DW-1:0]   src_rem_s;
    logic [DW-1:0]   src_quo_s;
    logic [DW-1:0]   src_dvs_s;
    logic [DW:0]     trial_s;
    logic [DW:0]     diff_s;
    logic [DW-1:0]   rem_nx_s;
    logic [DW-1:0]   quo_nx_s;

    // One restoring step, taken from fresh operands on start or from the running state
    always_comb begin
        src_rem_s = rem_r;
        src_quo_s = quo_r;
        src_dvs_s = dvs_r;
        if (start) begin
            src_rem_s = '0;
            src_quo_s = dividend;
            src_dvs_s = divisor;
        end else begin
            src_rem_s = rem_r;
        end
        trial_s = {src_rem_s, src_quo_s[DW-1]};
        diff_s  = trial_s - {1'b0, src_dvs_s};
        if (trial_s >= {1'b0, src_dvs_s}) begin
            rem_nx_s = diff_s[DW-1:0];
            quo_nx_s = {src_quo_s[DW-2:0], 1'b1};
        end else begin
            rem_nx_s = trial_s[DW-1:0];
            quo_nx_s = {src_quo_s[DW-2:0], 1'b0};
        end
    end

    // Divider state: load on start, then DW-1 further steps, done pulses after the last
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_r  <= '0;
            quo_r  <= '0;
            dvs_r  <= '0;
            cnt_r  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (start) begin
            rem_r  <= rem_nx_s;
            quo_r  <= quo_nx_s;
            dvs_r  <= src_dvs_s;
            cnt_r  <= CNTW'(DW - 1);
            busy_r <= 1'b1;
            done_r <= 1'b0;
        end else if (busy_r) begin
            rem_r <= rem_nx_s;
            quo_r <= quo_nx_s;
            cnt_r <= cnt_r - CNTW'(1);
            if (cnt_r == CNTW'(1)) begin
                busy_r <= 1'b0;
                done_r <= 1'b1;
            end else begin
                done_r <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign quotient = quo_r;
    assign done     = done_r;

endmodule

// File: rtl/trilat_locator.sv
// trilat_locator: trilaterates x/y from three distances with one shared serial
// divider and maps the clamped point to a matrix cell. Build macro: TRILAT_LED_MASK_EN.
module trilat_locator
    import trilat_pkg::*;
#(
    parameter int W        = DEF_W,
    parameter int SIDE     = DEF_SIDE,
    parameter int XS3      = DEF_XS3,
    parameter int YS3      = DEF_YS3,
    parameter int MAX_DIST = DEF_MAX_DIST,
    parameter int ROWS     = DEF_ROWS,
    parameter int COLS     = DEF_COLS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         d1,
    input  logic [W-1:0]         d2,
    input  logic [W-1:0]         d3,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         x_pos,
    output logic [W-1:0]         y_pos,
    output logic [4:0]           col,
    output logic [4:0]           row,
    output logic                 out_clamped,
    output logic                 out_err,
    output logic [ROWS*COLS-1:0] led_mask
);

    localparam int NWL = calc_dw(W);
    localparam int LN  = ROWS * COLS;

    localparam logic [NWL-1:0] K_SIDE2  = NWL'(SIDE * SIDE);
    localparam logic [NWL-1:0] K_YOFF   = NWL'(XS3 * XS3 + YS3 * YS3);
    localparam logic [NWL-1:0] K_2XS3   = NWL'(2 * XS3);
    localparam logic [NWL-1:0] K_2SIDE  = NWL'(2 * SIDE);
    localparam logic [NWL-1:0] K_2YS3   = NWL'(2 * YS3);
    localparam logic [NWL-1:0] K_SIDE   = NWL'(SIDE);
    localparam logic [NWL-1:0] K_YS3    = NWL'(YS3);
    localparam logic [NWL-1:0] K_COLS   = NWL'(COLS);
    localparam logic [NWL-1:0] K_ROWS   = NWL'(ROWS);
    localparam logic [NWL-1:0] K_COLMAX = NWL'(COLS - 1);
    localparam logic [NWL-1:0] K_ROWMAX = NWL'(ROWS - 1);

    state_e         state_r;
    state_e         next_s;

    logic [W-1:0]   d1_r;
    logic [W-1:0]   d2_r;
    logic [W-1:0]   d3_r;
    logic [W-1:0]   x_r;
    logic [W-1:0]   y_r;
    logic [4:0]     col_r;
    logic [4:0]     row_r;
    logic           clx_r;
    logic           cly_r;
    logic           out_valid_r;
    logic           out_clamped_r;
    logic           out_err_r;

    logic [NWL-1:0] d1_e_s;
    logic [NWL-1:0] d2_e_s;
    logic [NWL-1:0] d3_e_s;
    logic [NWL-1:0] x_src_e_s;
    logic [NWL-1:0] nx_s;
    logic [NWL-1:0] ny_s;
    logic [NWL-1:0] dividend_s;
    logic [NWL-1:0] divisor_s;
    logic [NWL-1:0] quot_s;
    logic           div_start_s;
    logic           div_done_s;
    logic           in_bad_s;
    logic [W-1:0]   x_new_s;
    logic [W-1:0]   y_new_s;
    logic           x_clip_s;
    logic           y_clip_s;
    logic [4:0]     col_new_s;
    logic [4:0]     row_new_s;

    assign d1_e_s = {{(NWL-W){1'b0}}, d1_r};
    assign d2_e_s = {{(NWL-W){1'b0}}, d2_r};
    assign d3_e_s = {{(NWL-W){1'b0}}, d3_r};

    // Modular arithmetic in NWL bits; the MSB is the sign of the exact numerator.
    assign x_src_e_s = (state_r == DIV_X) ? {{(NWL-W){1'b0}}, x_new_s}
                                          : {{(NWL-W){1'b0}}, x_r};
    assign nx_s = d1_e_s * d1_e_s - d2_e_s * d2_e_s + K_SIDE2;
    assign ny_s = d1_e_s * d1_e_s - d3_e_s * d3_e_s + K_YOFF - K_2XS3 * x_src_e_s;

    assign in_bad_s = (d1_r == W'(0)) || (d2_r == W'(0)) || (d3_r == W'(0)) ||
                      (d1_r > W'(MAX_DIST)) || (d2_r > W'(MAX_DIST)) ||
                      (d3_r > W'(MAX_DIST));

    serial_div #(
        .DW (NWL)
    ) u_div (
        .clk      (clk),
        .rst_n    (reset),
        .start    (div_start_s),
        .dividend (dividend_s),
        .divisor  (divisor_s),
        .quotient (quot_s),
        .done     (div_done_s)
    );

    // Clamp the current quotient into coordinate and cell ranges
    always_comb begin
        x_new_s   = '0;
        x_clip_s  = 1'b0;
        y_new_s   = '0;
        y_clip_s  = 1'b0;
        col_new_s = '0;
        row_new_s = '0;
        if (nx_s[NWL-1]) begin
            x_clip_s = 1'b1;
        end else if (quot_s > K_SIDE) begin
            x_new_s  = W'(SIDE);
            x_clip_s = 1'b1;
        end else begin
            x_new_s  = quot_s[W-1:0];
        end
        if (ny_s[NWL-1]) begin
            y_clip_s = 1'b1;
        end else if (quot_s > K_YS3) begin
            y_new_s  = W'(YS3);
            y_clip_s = 1'b1;
        end else begin
            y_new_s  = quot_s[W-1:0];
        end
        if (quot_s > K_COLMAX) begin
            col_new_s = 5'(COLS - 1);
        end else begin
            col_new_s = quot_s[4:0];
        end
        if (quot_s > K_ROWMAX) begin
            row_new_s = 5'(ROWS - 1);
        end else begin
            row_new_s = quot_s[4:0];
        end
    end

    // Next state and divider launch; each division starts as the previous one reports done
    always_comb begin
        next_s      = state_r;
        div_start_s = 1'b0;
        dividend_s  = '0;
        divisor_s   = '0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    next_s = CHECK;
                end else begin
                    next_s = IDLE;
                end
            end
            CHECK: begin
                if (in_bad_s) begin
                    next_s = ERR;
                end else begin
                    next_s      = DIV_X;
                    div_start_s = 1'b1;
                    dividend_s  = nx_s[NWL-1] ? '0 : nx_s;
                    divisor_s   = K_2SIDE;
                end
            end
            ERR: next_s = DONE;
            DIV_X: begin
                if (div_done_s) begin
                    next_s      = DIV_Y;
                    div_start_s = 1'b1;
                    dividend_s  = ny_s[NWL-1] ? '0 : ny_s;
                    divisor_s   = K_2YS3;
                end else begin
                    next_s = DIV_X;
                end
            end
            DIV_Y: begin
                if (div_done_s) begin
                    next_s      = DIV_C;
                    div_start_s = 1'b1;
                    dividend_s  = {{(NWL-W){1'b0}}, x_r} * K_COLS;
                    divisor_s   = K_SIDE;
                end else begin
                    next_s = DIV_Y;
                end
            end
            DIV_C: begin
                if (div_done_s) begin
                    next_s      = DIV_R;
                    div_start_s = 1'b1;
                    dividend_s  = {{(NWL-W){1'b0}}, y_r} * K_ROWS;
                    divisor_s   = K_YS3;
                end else begin
                    next_s = DIV_C;
                end
            end
            DIV_R: begin
                if (div_done_s) begin
                    next_s = DONE;
                end else begin
                    next_s = DIV_R;
                end
            end
            DONE: begin
                if (out_valid_r && out_ready) begin
                    next_s = IDLE;
                end else begin
                    next_s = DONE;
                end
            end
            default: next_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Operand capture and result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            d1_r          <= '0;
            d2_r          <= '0;
            d3_r          <= '0;
            x_r           <= '0;
            y_r           <= '0;
            col_r         <= '0;
            row_r         <= '0;
            clx_r         <= 1'b0;
            cly_r         <= 1'b0;
            out_valid_r   <= 1'b0;
            out_clamped_r <= 1'b0;
            out_err_r     <= 1'b0;
        end else begin
            if (state_r == IDLE && in_valid) begin
                d1_r <= d1;
                d2_r <= d2;
                d3_r <= d3;
            end
            case (state_r)
                ERR: begin
                    out_err_r     <= 1'b1;
                    out_clamped_r <= 1'b0;
                    out_valid_r   <= 1'b1;
                end
                DIV_X: begin
                    if (div_done_s) begin
                        x_r   <= x_new_s;
                        clx_r <= x_clip_s;
                    end
                end
                DIV_Y: begin
                    if (div_done_s) begin
                        y_r   <= y_new_s;
                        cly_r <= y_clip_s;
                    end
                end
                DIV_C: begin
                    if (div_done_s) begin
                        col_r <= col_new_s;
                    end
                end
                DIV_R: begin
                    if (div_done_s) begin
                        row_r         <= row_new_s;
                        out_clamped_r <= clx_r | cly_r;
                        out_err_r     <= 1'b0;
                    end
                end
                DONE: begin
                    // Valid results spend one settling cycle in DONE before presenting
                    if (!out_valid_r) begin
                        out_valid_r <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef TRILAT_LED_MASK_EN
    logic [LN-1:0] led_r;
    logic [LN-1:0] one_hot_s;

    assign one_hot_s = LN'(1) << (int'(row_new_s) * COLS + int'(col_r));

    // LED cell register, refreshed only by valid results
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_r <= '0;
        end else if (state_r == DIV_R && div_done_s) begin
            led_r <= one_hot_s;
        end
    end

    assign led_mask = led_r;
`else
    assign led_mask = '0;
`endif

    assign in_ready    = (state_r == IDLE);
    assign out_valid   = out_valid_r;
    assign x_pos       = x_r;
    assign y_pos       = y_r;
    assign col         = col_r;
    assign row         = row_r;
    assign out_clamped = out_clamped_r;
    assign out_err     = out_err_r;

endmodule

// File: tb/tb_trilat_locator.sv
// tb_trilat_locator: directed and random triples checked against an integer
// trilateration reference model, including latency, backpressure and reset abort.
module tb_trilat_locator;

    localparam int W     = 12;
    localparam int SIDE  = 75;
    localparam int XS3   = 37;
    localparam int YS3   = 66;
    localparam int MAXD  = 127;
    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int LAT_V = 4 * (2 * W + 3) + 2;
    localparam int LAT_E = 2;

    logic                 clk;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [W-1:0]         d1;
    logic [W-1:0]         d2;
    logic [W-1:0]         d3;
    logic                 out_valid;
    logic                 out_ready;
    logic [W-1:0]         x_pos;
    logic [W-1:0]         y_pos;
    logic [4:0]           col;
    logic [4:0]           row;
    logic                 out_clamped;
    logic                 out_err;
    logic [ROWS*COLS-1:0] led_mask;

    int checks;
    int failures;

    int          e_x, e_y, e_col, e_row, e_clamped, e_err;
    logic [63:0] e_led;

    trilat_locator dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .d1          (d1),
        .d2          (d2),
        .d3          (d3),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .col         (col),
        .row         (row),
        .out_clamped (out_clamped),
        .out_err     (out_err),
        .led_mask    (led_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_led(input string tag);
        checks++;
        assert (led_mask === e_led) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, led_mask, e_led);
        end
    endtask

    task automatic model_reset();
        e_x = 0; e_y = 0; e_col = 0; e_row = 0; e_clamped = 0; e_err = 0;
        e_led = 64'd0;
    endtask

    // Reference: exact integer trilateration, clamping and cell mapping
    task automatic model(input int a, input int b, input int c);
        int nx, ny, x, y, cl;
        if (a == 0 || b == 0 || c == 0 || a > MAXD || b > MAXD || c > MAXD) begin
            e_err = 1;
            e_clamped = 0;
        end else begin
            cl = 0;
            nx = a * a - b * b + SIDE * SIDE;
            if (nx < 0) begin x = 0; cl = 1; end
            else begin
                x = nx / (2 * SIDE);
                if (x > SIDE) begin x = SIDE; cl = 1; end
            end
            ny = a * a - c * c + XS3 * XS3 + YS3 * YS3 - 2 * XS3 * x;
            if (ny < 0) begin y = 0; cl = 1; end
            else begin
                y = ny / (2 * YS3);
                if (y > YS3) begin y = YS3; cl = 1; end
            end
            e_x = x;
            e_y = y;
            e_col = (x * COLS) / SIDE;
            if (e_col > COLS - 1) e_col = COLS - 1;
            e_row = (y * ROWS) / YS3;
            if (e_row > ROWS - 1) e_row = ROWS - 1;
            e_clamped = cl;
            e_err = 0;
`ifdef TRILAT_LED_MASK_EN
            e_led = 64'd1 << (e_row * COLS + e_col);
`else
            e_led = 64'd0;
`endif
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".x_pos"}, int'(x_pos), e_x);
        check({tag, ".y_pos"}, int'(y_pos), e_y);
        check({tag, ".col"}, int'(col), e_col);
        check({tag, ".row"}, int'(row), e_row);
        check({tag, ".clamped"}, int'(out_clamped), e_clamped);
        check({tag, ".err"}, int'(out_err), e_err);
        check_led({tag, ".led"});
    endtask

    // One triple through the block; 'hold' cycles of backpressure with a pending request
    task automatic run(input int a, input int b, input int c, input int hold, input string tag);
        int cyc;
        bit seen;
        model(a, b, c);
        @(negedge clk);
        d1 = W'(a); d2 = W'(b); d3 = W'(c);
        in_valid = 1'b1;
        out_ready = 1'b0;
        check({tag, ".in_ready"}, int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(posedge clk);
            cyc++;
            #1;
            seen = out_valid;
        end
        check({tag, ".latency"}, cyc, (e_err != 0) ? LAT_E : LAT_V);
        @(negedge clk);
        check_outputs(tag);
        if (hold > 0) begin
            d1 = W'(50); d2 = W'(50); d3 = W'(50);
            in_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check({tag, ".hold_valid"}, int'(out_valid), 1);
                check({tag, ".hold_ready"}, int'(in_ready), 0);
                check({tag, ".hold_x"}, int'(x_pos), e_x);
                check({tag, ".hold_row"}, int'(row), e_row);
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, ".taken_valid"}, int'(out_valid), 0);
        check({tag, ".taken_idle"}, int'(in_ready), 1);
        if (hold > 0) begin
            repeat (2) @(negedge clk);
            check({tag, ".no_accept"}, int'(in_ready), 1);
        end
    endtask

    initial begin
        int a, b, c;
        bit stale;
        checks = 0;
        failures = 0;
        model_reset();
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        d1 = '0; d2 = '0; d3 = '0;
        #12;
        check("rst.in_ready", int'(in_ready), 1);
        check("rst.out_valid", int'(out_valid), 0);
        check_outputs("rst");
        @(negedge clk);
        reset = 1'b1;

        run(39, 42, 51, 0, "s1");
        run(39, 0, 51, 0, "err_d2");
        run(1, 75, 66, 0, "s2");
        run(100, 100, 1, 0, "s3");
        run(20, 30, 128, 0, "err_d3");
        run(39, 42, 51, 10, "bp");

        for (int k = 0; k < 8; k++) begin
            a = $urandom_range(127, 1);
            b = $urandom_range(127, 1);
            c = $urandom_range(127, 1);
            if ($urandom_range(7, 0) == 0) b = 0;
            if ($urandom_range(7, 0) == 0) c = $urandom_range(200, 128);
            run(a, b, c, 0, "rnd");
        end

        // Abort a computation part-way through
        @(negedge clk);
        d1 = W'(39); d2 = W'(42); d3 = W'(51);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        model_reset();
        check("abort.in_ready", int'(in_ready), 1);
        check("abort.out_valid", int'(out_valid), 0);
        check_outputs("abort");
        @(negedge clk);
        reset = 1'b1;
        stale = 1'b0;
        repeat (120) begin
            @(negedge clk);
            stale = stale | out_valid;
        end
        check("abort.no_stale", int'(stale), 0);
        run(39, 42, 51, 0, "after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trilat_locator.md
Name: trilat_locator

Overview:
- Parametrised, sequential successor of the fixed 75-unit, 8x8 geometry block.
- Accepts one triple of ultrasonic distances (sensors at (0,0), (SIDE,0) and (XS3,YS3)) over a valid/ready handshake.
- Computes x/y by trilateration with a shared serial divider, clamps the result and maps it to a ROWS x COLS LED-matrix cell.
- Sits between the three HC-SR04 echo-measurement blocks and the matrix driver.

Parameters:
- W, 12: distance/coordinate width (unsigned).
- SIDE, 75: x of sensor 2; x range 0..SIDE.
- XS3, 37: x of sensor 3; must equal SIDE/2 floored.
- YS3, 66: y of sensor 3; y range 0..YS3.
- MAX_DIST, 127: largest legal distance; 0 means "no echo".
- ROWS, 8: matrix rows (2..16).
- COLS, 8: matrix columns (2..16).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  distance triple valid
- in_ready  out  1  block idle, can accept
- d1  in  W  distance to sensor 1
- d2  in  W  distance to sensor 2
- d3  in  W  distance to sensor 3
- out_valid  out  1  result valid, held until taken
- out_ready  in  1  consumer accepts result
- x_pos  out  W  clamped x
- y_pos  out  W  clamped y
- col  out  5  column index 0..COLS-1
- row  out  5  row index 0..ROWS-1
- out_clamped  out  1  x or y was clamped
- out_err  out  1  input rejected (0 or >MAX_DIST)
- led_mask  out  ROWS*COLS  one-hot cell (see Optional Feature)

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. in_ready=1 (combinational from IDLE). All other outputs 0. Divider cleared.
- Reset mid-operation: aborts the computation; no out_valid is produced for the aborted triple.
- Handshake: accept when in_valid & in_ready; d1..d3 are latched on that edge. in_ready=0 outside IDLE.
- out_valid stays high with all outputs stable until out_valid & out_ready, then the block returns to IDLE. No new accept occurs in that same cycle.
- FSM: IDLE -> CHECK -> (ERR | DIV_X -> DIV_Y -> DIV_C -> DIV_R) -> DONE -> IDLE.
- CHECK:
  - If any d==0 or d>MAX_DIST, go to ERR.
  - ERR sets out_err=1 and enters DONE next cycle.
  - x_pos/y_pos/col/row keep their previous values.
  - Error latency: out_valid 2 cycles after accept.
- Arithmetic (signed, width 2W+3, exact):
  - NX = d1^2 - d2^2 + SIDE^2, x = NX/(2*SIDE).
  - NY = d1^2 - d3^2 + XS3^2 + YS3^2 - 2*XS3*x, y = NY/(2*YS3).
  - Negative numerator -> result 0, clamped.
  - x > SIDE -> SIDE, clamped; y > YS3 -> YS3, clamped.
  - col = (x*COLS)/SIDE and row = (y*ROWS)/YS3, each floored, then limited to COLS-1 / ROWS-1. This limit does not set out_clamped.
- Divider:
  - Unsigned restoring, one quotient bit per cycle, DW = 2W+3 cycles per division.
  - Each DIV_* state starts the divider on entry and leaves when it reports done.
- Valid latency: out_valid exactly 4*DW+2 cycles after accept (110 for W=12).
- out_clamped and out_err are updated per result; out_err=0 on valid results.

Optional Feature:
- Macro TRILAT_LED_MASK_EN.
- Defined: led_mask is registered with the result and is one-hot at bit row*COLS+col. On error it holds its previous value.
- Undefined: led_mask is constant 0 and no mask register is built.

Decomposition:
- Package trilat_pkg holds:
  - FSM state enum: IDLE, CHECK, ERR, DIV_X, DIV_Y, DIV_C, DIV_R, DONE.
  - DW and numerator-width localparams.
  - Default geometry constants.
- Sub-module serial_div: parametrised width, start/done handshake, unsigned quotient. Instantiated once and shared by all four divisions.

Test Plan:
- d1=39, d2=42, d3=51 -> x_pos=35, y_pos=15, col=3, row=1, out_clamped=0, out_err=0; out_valid 110 cycles after accept.
- d1=1, d2=75, d3=66 -> x_pos=0, y_pos=10, col=0, row=1, out_clamped=0.
- d1=100, d2=100, d3=1 -> x_pos=37, y_pos=66 with out_clamped=1, col=3, row=7.
- d2=0 (or d3=128) -> out_err=1 two cycles after accept; x_pos/y_pos/col/row unchanged from the previous result.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0, a pending in_valid is not accepted. Then out_ready=1 -> IDLE next cycle.
- Assert reset at cycle 50 of a computation -> all outputs 0 immediately, no stale out_valid, next triple computes correctly. With TRILAT_LED_MASK_EN, the first scenario gives led_mask = 1<<11.
